// File: rtl/xram_16_if.sv
// Bus bundle for the single-port RAM: one shared address, write data, write enable, read data.
// The master drives the address and write side; the slave returns registered read data.
interface xram_16_if #(
  parameter int AW = 14,
  parameter int DW = 8
);
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic          we;
  logic [DW-1:0] dout;

  modport master (output addr, din, we, input dout);
  modport slave  (input addr, din, we, output dout);
endinterface

// File: rtl/xram_16.sv
// Single-port synchronous RAM, 2**AW x DW, one-cycle registered read, write-first; no backpressure.
// Reset clears only the read register, never the array, and wins over a write on the same edge.
module xram_16 #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic       clk,
  input  logic       rst,
  xram_16_if.slave   bus
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [0:DEPTH-1] = '{default: '0};

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.dout <= '0;
    end else if (bus.we) begin
      mem[bus.addr] <= bus.din;
      bus.dout      <= bus.din;
    end else begin
      bus.dout <= mem[bus.addr];
    end
  end

endmodule

// File: tb/tb_xram_16.sv
// Directed and random bench for xram_16, checked against a reference array model every cycle.
module tb_xram_16;

  localparam int AW    = 14;
  localparam int DW    = 8;
  localparam int DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  xram_16_if #(.AW(AW), .DW(DW)) bus ();

  xram_16 #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: plain array of stored words plus the value dout must show after each edge.
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  logic [DW-1:0] ref_dout;
  logic          ref_vld = 1'b0;

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  end

  always @(posedge clk) begin
    ref_vld <= 1'b1;
    if (rst)
      ref_dout <= '0;
    else if (bus.we) begin
      ref_mem[bus.addr] <= bus.din;
      ref_dout          <= bus.din;
    end else
      ref_dout <= ref_mem[bus.addr];
  end

  always @(negedge clk) begin
    if (ref_vld) begin
      n_checks++;
      if (bus.dout !== ref_dout) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t dout=%h expected=%h", $time, bus.dout, ref_dout);
      end
    end
  end

  // Apply one operation across one rising edge; returns at the following falling edge.
  task automatic cyc(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rst      = r;
    bus.we   = w;
    bus.addr = a;
    bus.din  = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [DW-1:0] exp);
    n_checks++;
    if (bus.dout !== exp) begin
      n_fail++;
      $display("FAIL %s dout=%h expected=%h", name, bus.dout, exp);
    end
  endtask

  initial begin
    logic          r_w, r_r;
    logic [AW-1:0] r_a;
    logic [DW-1:0] r_d;

    // reset, then read of an unwritten location
    cyc(1'b1, 1'b0, 14'h0000, 8'h00);
    cyc(1'b1, 1'b0, 14'h0000, 8'h00);
    chk("reset_dout", 8'h00);
    cyc(1'b0, 1'b0, 14'h0005, 8'h00);
    chk("read_unwritten", 8'h00);

    // basic write/read
    cyc(1'b0, 1'b1, 14'h0123, 8'hA5);
    cyc(1'b0, 1'b1, 14'h0124, 8'h3C);
    cyc(1'b0, 1'b0, 14'h0123, 8'h00);
    chk("read_0123", 8'hA5);
    cyc(1'b0, 1'b0, 14'h0124, 8'h00);
    chk("read_0124", 8'h3C);

    // address extremes and a middle address that must stay untouched
    cyc(1'b0, 1'b1, 14'h0000, 8'h11);
    cyc(1'b0, 1'b1, 14'h3FFF, 8'hEE);
    cyc(1'b0, 1'b0, 14'h0000, 8'h00);
    chk("read_0000", 8'h11);
    cyc(1'b0, 1'b0, 14'h3FFF, 8'h00);
    chk("read_3FFF", 8'hEE);
    cyc(1'b0, 1'b0, 14'h2000, 8'h00);
    chk("read_2000", 8'h00);

    // write-first and back-to-back read
    cyc(1'b0, 1'b1, 14'h0040, 8'h7E);
    chk("write_first", 8'h7E);
    cyc(1'b0, 1'b0, 14'h0040, 8'h00);
    chk("read_0040", 8'h7E);

    // reset beats write, array survives reset
    cyc(1'b0, 1'b1, 14'h0010, 8'h55);
    chk("write_0010", 8'h55);
    cyc(1'b1, 1'b1, 14'h0010, 8'hFF);
    chk("reset_over_write", 8'h00);
    cyc(1'b0, 1'b0, 14'h0010, 8'h00);
    chk("retained_0010", 8'h55);

    // random traffic, concentrated on a small window so reads often hit written words
    for (int i = 0; i < 1000; i++) begin
      r_r = ($urandom_range(0, 99) == 0);
      r_w = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0:       r_a = AW'($urandom);
        1:       r_a = ($urandom_range(0, 1) == 1) ? 14'h3FFF : 14'h0000;
        default: r_a = 14'h0100 + AW'($urandom_range(0, 15));
      endcase
      r_d = DW'($urandom);
      cyc(r_r, r_w, r_a, r_d);
    end

    cyc(1'b0, 1'b0, 14'h0040, 8'h00);
    chk("final_0040", 8'h7E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xram_16.md
XRAM_16 -- requirements
Module: xram_16

Interface
REQ-001 The module SHALL expose parameter AW, default 14, meaning address width in bits.
REQ-002 The module SHALL expose parameter DW, default 8, meaning data width in bits.
REQ-003 The module SHALL set storage depth to 2**AW words of DW bits, which is 16384 x 8 at the defaults.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-006 The module SHALL have port addr, input, AW bits: word address for both read and write.
REQ-007 The module SHALL have port din, input, DW bits: write data.
REQ-008 The module SHALL have port we, input, 1 bit: write enable, active-high.
REQ-009 The module SHALL have port dout, output, DW bits: registered read data.

Function
REQ-010 The module SHALL behave as a single-port synchronous RAM with one address shared by read and write.
REQ-011 On a rising clk edge with rst=0 and we=1, the module SHALL write mem[addr] <= din.
REQ-012 On a rising clk edge with rst=0 and we=0, the module SHALL load dout <= mem[addr].
REQ-013 Read latency SHALL be exactly one clock: data for the addr sampled at edge N appears on dout after edge N and holds until the next update.
REQ-014 Read-during-write SHALL be write-first: on a write edge, dout <= din, the newly written value.
REQ-015 When we=0, mem SHALL be unchanged.
REQ-016 dout SHALL change only on rising clk edges, with no combinational path from addr, din or we to dout.
REQ-017 All 2**AW addresses SHALL be valid; addr 0 and addr 2**AW-1 SHALL behave identically to other addresses, with no wrap and no aliasing.
REQ-018 Back-to-back operations (write then read of the same address on consecutive edges) SHALL return the written value with no stall.
REQ-019 Memory contents SHALL be initialised to all zeros at configuration/simulation start.
REQ-020 The memory array SHALL be inferable as block RAM: one synchronous write port and one registered read port.

Reset
REQ-021 On a rising clk edge with rst=1, the module SHALL force dout to 0.
REQ-022 rst SHALL take priority over we: no write occurs on an edge where rst=1.
REQ-023 Reset SHALL NOT clear memory contents; data written before reset SHALL be readable after rst is deasserted.
REQ-024 After rst deasserts, the first read SHALL follow REQ-012/REQ-013 with no extra latency.

Verification
REQ-025 The bench SHALL cover the reset scenario: rst=1 for 2 clocks -> dout=0x00; then read addr 0x0005 without writing -> dout=0x00 one clock later.
REQ-026 The bench SHALL cover write/read: write 0xA5 to 0x0123, then write 0x3C to 0x0124, then read 0x0123 -> dout=0xA5 one clock after the read edge; read 0x0124 -> dout=0x3C.
REQ-027 The bench SHALL cover boundary addresses: write 0x11 to 0x0000 and 0xEE to 0x3FFF; read both -> 0x11 and 0xEE, and 0x2000 remains 0x00.
REQ-028 The bench SHALL cover write-first: with we=1, addr=0x0040, din=0x7E -> dout=0x7E after that edge; the next read of 0x0040 -> 0x7E.
REQ-029 The bench SHALL cover reset priority and retention: write 0x55 to 0x0010; assert rst with we=1, din=0xFF, addr=0x0010 for 1 clock -> dout=0x00; deassert rst and read 0x0010 -> 0x55.
REQ-030 The bench SHALL cover a random test: 1000 random read/write cycles checked against a reference array model, with dout compared every cycle per REQ-013/REQ-014.
